led_share_arbiter: RTL and testbench
====================================

LED_SHARE_ARBITER -- requirements
Module: led_share_arbiter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 24'd12_000, giving sys_clk cycles per tick (0.5 ms at 24 MHz).
REQ-002 The block SHALL have parameter SLOT_TICKS, default 16'd1000, giving ticks per grant slot (0.5 s).
REQ-003 The block SHALL have parameter GAP_TICKS, default 16'd20, giving blank ticks between owners (10 ms).
REQ-004 The block SHALL have port sys_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port sys_rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The block SHALL have port req, input, 3 bits, one level-sensitive LED request per requester 0..2.
REQ-007 The block SHALL have ports color0, color1 and color2, input, 3 bits each, active-high colour {B,R,G} per requester.
REQ-008 The block SHALL have port gnt, output, 3 bits, registered one-hot current owner, or 0 when there is none.
REQ-009 The block SHALL have port led, output, 3 bits, registered and active-low: bit0 G, bit1 R, bit2 B; 3'b111 is dark.
REQ-010 The block SHALL have port busy, output, 1 bit, high in GRANT and GAP states.

Function
REQ-011 The block SHALL use a three-state FSM: IDLE, GRANT, GAP.
REQ-012 Prescaler: counts 0..TICK_DIV-1; tick pulses for one cycle at TICK_DIV-1; prescaler and tick counter clear to 0 on every entry to GRANT or GAP.
REQ-013 IDLE: when req!=0 in cycle N, the block SHALL select the owner round-robin, first set bit after last_owner in order 0->1->2->0, and enter GRANT in cycle N+1.
REQ-014 IDLE: while req==0 the block SHALL stay in IDLE, keep gnt=0 and led=3'b111.
REQ-015 GRANT: gnt SHALL be the owner's one-hot; led SHALL equal ~color of the owner sampled the previous cycle (1-cycle latency; colour changes track live).
REQ-016 GRANT, owner drops req: the block SHALL enter GAP next cycle; last_owner SHALL be set to the owner.
REQ-017 GRANT, slot expiry (SLOT_TICKS ticks counted) with any other req bit set: the block SHALL enter GAP; last_owner SHALL be set to the owner.
REQ-018 GRANT, slot expiry with only the owner requesting: the block SHALL restart the slot, keep the owner, and produce no gap or led glitch.
REQ-019 Simultaneous expiry and owner drop: owner drop takes precedence (GAP).
REQ-020 GAP: gnt=0, led=3'b111; after GAP_TICKS ticks the block SHALL return to IDLE, and arbitration SHALL follow the IDLE rule (grant earliest 1 cycle later).
REQ-021 Slot length from GRANT entry to expiry SHALL be exactly SLOT_TICKS*TICK_DIV cycles; gap length SHALL be exactly GAP_TICKS*TICK_DIV cycles.
REQ-022 GAP_TICKS=0 SHALL give a GAP state of one cycle.
REQ-023 Requests arriving during GAP or GRANT SHALL be held by req level only; the block SHALL not latch them.
REQ-024 A colour of 3'b000 SHALL still count as a grant (dark LED, gnt set).

Reset
REQ-025 While sys_rst=1 the block SHALL force state IDLE, gnt=0, led=3'b111, busy=0, prescaler=0, tick counter=0, last_owner=2 (requester 0 has first priority).
REQ-026 Reset mid-grant or mid-gap SHALL take effect immediately, asynchronously; after release, arbitration SHALL restart from the IDLE rule.

Verification
(params TICK_DIV=4, SLOT_TICKS=3, GAP_TICKS=1)
REQ-027 Reset release with req=3'b111 -> gnt=3'b001 one cycle after first IDLE sample; led=~color0.
REQ-028 req=3'b001 held, color0=3'b010 -> gnt stays 3'b001 across slot expiry at cycle 12; led stays 3'b101 with no gap.
REQ-029 req=3'b011 from reset -> owner 0 for 12 cycles, then GAP 4 cycles with led=3'b111 and gnt=0, then gnt=3'b010 next cycle.
REQ-030 All req high continuously -> grant order 0,1,2,0; each slot is 12 cycles and each gap is 4 cycles.
REQ-031 Owner 1 drops req at cycle 5 of its slot -> GAP next cycle; next grant goes to requester 2 if requesting, else to 0.
REQ-032 sys_rst asserted mid-GRANT -> gnt=0, led=3'b111, busy=0 in the same cycle; after release with req=3'b100 -> gnt=3'b100.

Source files
------------

// File: rtl/led_share_arbiter_if.sv
// Bundle of the LED-sharing signals between requesters and the arbiter.
//   req            : per-requester level-sensitive LED request (bit n = requester n)
//   color0..color2 : active-high colour {B,R,G} offered by each requester
//   gnt            : one-hot current owner, 0 when nobody owns the LED
//   led            : active-low LED drive (bit0 G, bit1 R, bit2 B), 3'b111 = dark
//   busy           : arbiter is granting or blanking between owners
// master = requester side, slave = arbiter side.
interface led_share_arbiter_if;
  logic [2:0] req;
  logic [2:0] color0;
  logic [2:0] color1;
  logic [2:0] color2;
  logic [2:0] gnt;
  logic [2:0] led;
  logic       busy;

  modport master (
    output req, color0, color1, color2,
    input  gnt, led, busy
  );

  modport slave (
    input  req, color0, color1, color2,
    output gnt, led, busy
  );
endinterface

// File: rtl/led_share_arbiter.sv
// Time-sliced round-robin sharing of one RGB LED among three requesters.
// An owner keeps the LED for a slot of SLOT_TICKS ticks (re-armed while nobody
// else wants it), and owners are separated by a dark gap of GAP_TICKS ticks.
// Ports:
//   sys_clk : single clock, all state changes on its rising edge
//   sys_rst : asynchronous active-high reset
//   bus     : led_share_arbiter_if.slave (req/colours in, gnt/led/busy out)
// Parameters:
//   TICK_DIV   : sys_clk cycles per tick
//   SLOT_TICKS : ticks per grant slot
//   GAP_TICKS  : blank ticks between owners (0 gives a one-cycle gap)
module led_share_arbiter #(
  parameter logic [23:0] TICK_DIV   = 24'd12_000,
  parameter logic [15:0] SLOT_TICKS = 16'd1000,
  parameter logic [15:0] GAP_TICKS  = 16'd20
) (
  input logic                sys_clk,
  input logic                sys_rst,
  led_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic [23:0] presc_q, presc_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  led_q, led_d;

  logic tick;
  logic slot_done;
  logic gap_done;
  logic others_req;

  // First requester strictly after 'last' in the cyclic order 0->1->2->0.
  // Walking the candidates from farthest to nearest lets the nearest win.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    logic [2:0] sum;
    pick = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      sum = {1'b0, last} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (r[sum[1:0]]) pick = sum[1:0];
    end
    return pick;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  function automatic logic [2:0] color_of(input logic [1:0] idx,
                                          input logic [2:0] c0,
                                          input logic [2:0] c1,
                                          input logic [2:0] c2);
    logic [2:0] c;
    case (idx)
      2'd0:    c = c0;
      2'd1:    c = c1;
      default: c = c2;
    endcase
    return c;
  endfunction

  assign tick       = (presc_q == TICK_DIV - 24'd1);
  assign slot_done  = tick && (tick_cnt_q == SLOT_TICKS - 16'd1);
  assign gap_done   = (GAP_TICKS == 16'd0) || (tick && (tick_cnt_q == GAP_TICKS - 16'd1));
  assign others_req = |(bus.req & ~onehot(owner_q));

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd2;
      presc_q      <= '0;
      tick_cnt_q   <= '0;
      gnt_q        <= 3'b000;
      led_q        <= 3'b111;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      presc_q      <= presc_d;
      tick_cnt_q   <= tick_cnt_d;
      gnt_q        <= gnt_d;
      led_q        <= led_d;
    end
  end

  // Next-state logic. Timers are zero on every entry to GRANT or GAP, so slot
  // and gap lengths are exact multiples of TICK_DIV.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    presc_d      = tick ? '0 : presc_q + 24'd1;
    tick_cnt_d   = tick ? tick_cnt_q + 16'd1 : tick_cnt_q;
    case (state_q)
      IDLE: begin
        // Timers parked at zero so GRANT starts with a fresh slot.
        presc_d    = '0;
        tick_cnt_d = '0;
        if (|bus.req) begin
          state_d = GRANT;
          owner_d = rr_pick(bus.req, last_owner_q);
        end
      end
      GRANT: begin
        // Owner release wins over a coincident slot expiry.
        if (!bus.req[owner_q] || (slot_done && others_req)) begin
          state_d      = GAP;
          last_owner_d = owner_q;
          presc_d      = '0;
          tick_cnt_d   = '0;
        end else if (slot_done) begin
          // Nobody else waiting: silently re-arm the slot for the same owner.
          presc_d    = '0;
          tick_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d    = IDLE;
          presc_d    = '0;
          tick_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        presc_d    = '0;
        tick_cnt_d = '0;
      end
    endcase
  end

  // Output logic: registered outputs follow the state being entered, so the
  // LED shows the owner's colour as sampled one cycle earlier.
  always_comb begin
    gnt_d = 3'b000;
    led_d = 3'b111;
    if (state_d == GRANT) begin
      gnt_d = onehot(owner_d);
      led_d = ~color_of(owner_d, bus.color0, bus.color1, bus.color2);
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.led  = led_q;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench: stimulus pushes every expected output change (cycle,
// gnt, led, busy); the monitor pops one entry each time the DUT outputs change.
module tb_led_share_arbiter;

  typedef struct {
    int         cyc;
    logic [2:0] gnt;
    logic [2:0] led;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  led_share_arbiter_if bus ();

  led_share_arbiter #(
    .TICK_DIV  (24'd4),
    .SLOT_TICKS(16'd3),
    .GAP_TICKS (16'd1)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [2:0] g, input logic [2:0] l, input logic b);
    exp_t e;
    e.cyc  = c;
    e.gnt  = g;
    e.led  = l;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  // Advance to just after the rising edge that starts cycle c.
  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every change of {gnt,led,busy} is one transaction.
  initial begin
    logic [6:0] prev;
    logic [6:0] obs;
    logic       have_prev;
    exp_t       e;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      obs = {bus.gnt, bus.led, bus.busy};
      if (!have_prev || obs != prev) begin
        have_prev = 1'b1;
        prev      = obs;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got gnt=%b led=%b busy=%b, required no change",
                   cyc, bus.gnt, bus.led, bus.busy);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.gnt != bus.gnt || e.led != bus.led || e.busy != bus.busy) begin
            n_fail++;
            $display("FAIL event got cyc=%0d gnt=%b led=%b busy=%b, required cyc=%0d gnt=%b led=%b busy=%b",
                     cyc, bus.gnt, bus.led, bus.busy, e.cyc, e.gnt, e.led, e.busy);
          end else begin
            $display("event cyc=%0d gnt=%b led=%b busy=%b ok", cyc, bus.gnt, bus.led, bus.busy);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d, required end by cycle 190", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.req    = 3'b111;
    bus.color0 = 3'b010;
    bus.color1 = 3'b100;
    bus.color2 = 3'b001;

    // Reset state, seen at the first falling edge.
    expect_ev(1, 3'b000, 3'b111, 1'b0);

    // Release with all requesting: order 0,1,2,0, 12-cycle slots, 4-cycle gaps.
    at_cycle(3);
    rst = 1'b0;
    expect_ev(4,  3'b001, 3'b101, 1'b1);
    expect_ev(16, 3'b000, 3'b111, 1'b1);
    expect_ev(20, 3'b000, 3'b111, 1'b0);
    expect_ev(21, 3'b010, 3'b011, 1'b1);
    expect_ev(33, 3'b000, 3'b111, 1'b1);
    expect_ev(37, 3'b000, 3'b111, 1'b0);
    expect_ev(38, 3'b100, 3'b110, 1'b1);
    expect_ev(50, 3'b000, 3'b111, 1'b1);
    expect_ev(54, 3'b000, 3'b111, 1'b0);
    expect_ev(55, 3'b001, 3'b101, 1'b1);

    // Asynchronous reset mid-grant, then only requester 2.
    at_cycle(60);
    expect_ev(60, 3'b000, 3'b111, 1'b0);
    rst     = 1'b1;
    bus.req = 3'b100;
    at_cycle(62);
    rst = 1'b0;
    expect_ev(63, 3'b100, 3'b110, 1'b1);

    // Sole requester: slot re-arms at 75 with no change; black colour still granted.
    at_cycle(80);
    bus.color2 = 3'b000;
    expect_ev(81, 3'b100, 3'b111, 1'b1);

    at_cycle(90);
    bus.req = 3'b000;
    expect_ev(91, 3'b000, 3'b111, 1'b1);
    expect_ev(95, 3'b000, 3'b111, 1'b0);

    // Owner 1 drops in cycle 5 of its slot; 0 and 2 waiting -> 2 is next.
    at_cycle(96);
    bus.req = 3'b010;
    expect_ev(97, 3'b010, 3'b011, 1'b1);
    at_cycle(102);
    bus.req    = 3'b101;
    bus.color2 = 3'b001;
    expect_ev(103, 3'b000, 3'b111, 1'b1);
    expect_ev(107, 3'b000, 3'b111, 1'b0);
    expect_ev(108, 3'b100, 3'b110, 1'b1);

    at_cycle(110);
    bus.req = 3'b000;
    expect_ev(111, 3'b000, 3'b111, 1'b1);
    expect_ev(115, 3'b000, 3'b111, 1'b0);

    // req=011: owner 0 for 12 cycles, gap, then owner 1.
    at_cycle(116);
    bus.req = 3'b011;
    expect_ev(117, 3'b001, 3'b101, 1'b1);
    expect_ev(129, 3'b000, 3'b111, 1'b1);
    expect_ev(133, 3'b000, 3'b111, 1'b0);
    expect_ev(134, 3'b010, 3'b011, 1'b1);

    // Owner drop in the very cycle the slot expires.
    at_cycle(145);
    bus.req = 3'b000;
    expect_ev(146, 3'b000, 3'b111, 1'b1);
    expect_ev(150, 3'b000, 3'b111, 1'b0);

    // After owner 1, requester 0 alone: held across expiries with no glitch.
    at_cycle(151);
    bus.req = 3'b001;
    expect_ev(152, 3'b001, 3'b101, 1'b1);
    at_cycle(180);
    bus.req = 3'b000;
    expect_ev(181, 3'b000, 3'b111, 1'b1);
    expect_ev(185, 3'b000, 3'b111, 1'b0);

    at_cycle(190);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got %0d outstanding, required 0 (next cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
